// File: rtl/packed_fifo_pkg.sv
// Shared defaults and width helpers for the packed element FIFO.
package packed_fifo_pkg;

   localparam int LINE_DEF   = 18;
   localparam int DEPTH_DEF  = 64;
   localparam int PUSH_W_DEF = 4;
   localparam int POP_W_DEF  = 2;

   // Pointer carries one extra wrap bit so full and empty stay distinct.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int lane_w(input int lanes);
      return $clog2(lanes + 1);
   endfunction

   function automatic int nbank(input int push_w, input int pop_w);
      int m;
      int n;
      m = (push_w > pop_w) ? push_w : pop_w;
      n = 1;
      while (n < m) n = n * 2;
      return n;
   endfunction

endpackage

// File: rtl/packed_fifo_if.sv
// Push/pop bundle of the packed FIFO; master drives counts and data, slave reports status.
interface packed_fifo_if
   import packed_fifo_pkg::*;
#(
   parameter int LINE   = LINE_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int PUSH_W = PUSH_W_DEF,
   parameter int POP_W  = POP_W_DEF
);
   localparam int PC_W  = lane_w(PUSH_W);
   localparam int OC_W  = lane_w(POP_W);
   localparam int CNT_W = cnt_w(DEPTH);

   logic [PC_W-1:0]        push_count;
   logic [PUSH_W*LINE-1:0] push_data;
   logic                   push_ready;
   logic [OC_W-1:0]        pop_count;
   logic [POP_W*LINE-1:0]  pop_data;
   logic [OC_W-1:0]        pop_avail;
   logic [CNT_W-1:0]       count;
   logic                   full;
   logic                   empty;

   modport master (
      output push_count, push_data, pop_count,
      input  push_ready, pop_data, pop_avail, count, full, empty
   );

   modport slave (
      input  push_count, push_data, pop_count,
      output push_ready, pop_data, pop_avail, count, full, empty
   );

endinterface

// File: rtl/packed_fifo_bank.sv
// One storage bank: one write port, one combinational read port, contents never reset.
module packed_fifo_bank #(
   parameter  int LINE = 18,
   parameter  int ROWS = 16,
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic            clk,
   input  logic            wr_en,
   input  logic [RW-1:0]   wr_row,
   input  logic [LINE-1:0] wr_dat,
   input  logic [RW-1:0]   rd_row,
   output logic [LINE-1:0] rd_dat
);

   logic [LINE-1:0] mem_q [ROWS];

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_row] <= wr_dat;
   end

   assign rd_dat = mem_q[rd_row];

endmodule

// File: rtl/packed_fifo.sv
// Multi-lane FIFO: up to PUSH_W in / POP_W out per cycle, FWFT read one cycle after write.
// All-or-nothing push gated by start-of-cycle free space; PACKED_FIFO_ERR_EN adds sticky err[1:0].
module packed_fifo
   import packed_fifo_pkg::*;
#(
   parameter int LINE   = LINE_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int PUSH_W = PUSH_W_DEF,
   parameter int POP_W  = POP_W_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   packed_fifo_if.slave fif
`ifdef PACKED_FIFO_ERR_EN
   ,
   output logic [1:0]   err
`endif
);

   localparam int NBANK  = nbank(PUSH_W, POP_W);
   localparam int ROWS   = DEPTH / NBANK;
   localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = ptr_w(DEPTH);
   localparam int OC_W   = lane_w(POP_W);

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W-1:0] cnt, free, push_n, pop_n, avail_n, eff_n;
   logic             push_ok, push_acc;

   logic [NBANK-1:0] wr_en;
   logic [RW-1:0]    wr_row [NBANK];
   logic [LINE-1:0]  wr_dat [NBANK];
   logic [RW-1:0]    rd_row [NBANK];
   logic [LINE-1:0]  rd_dat [NBANK];

   always_comb begin
      cnt      = head_q - tail_q;
      free     = PTR_W'(DEPTH) - cnt;
      push_n   = PTR_W'(fif.push_count);
      pop_n    = PTR_W'(fif.pop_count);
      push_ok  = (push_n <= free);
      push_acc = push_ok && (push_n != '0);
      avail_n  = (cnt < PTR_W'(POP_W)) ? cnt : PTR_W'(POP_W);
      eff_n    = (pop_n < avail_n) ? pop_n : avail_n;
      head_d   = push_acc ? head_q + push_n : head_q;
      tail_d   = tail_q + eff_n;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   // Consecutive lanes land in distinct banks because NBANK >= PUSH_W and POP_W.
   always_comb begin
      for (int b = 0; b < NBANK; b++) begin
         wr_en[b]  = 1'b0;
         wr_row[b] = '0;
         wr_dat[b] = '0;
      end
      for (int i = 0; i < PUSH_W; i++) begin
         int addr;
         addr = (int'(head_q[ADDR_W-1:0]) + i) % DEPTH;
         if (push_acc && (i < int'(fif.push_count))) begin
            wr_en[addr % NBANK]  = 1'b1;
            wr_row[addr % NBANK] = RW'(addr / NBANK);
            wr_dat[addr % NBANK] = fif.push_data[i*LINE +: LINE];
         end
      end
   end

   always_comb begin
      for (int b = 0; b < NBANK; b++) rd_row[b] = '0;
      for (int j = 0; j < POP_W; j++) begin
         int addr;
         addr = (int'(tail_q[ADDR_W-1:0]) + j) % DEPTH;
         rd_row[addr % NBANK] = RW'(addr / NBANK);
      end
   end

   always_comb begin
      fif.pop_data = '0;
      for (int j = 0; j < POP_W; j++) begin
         int addr;
         addr = (int'(tail_q[ADDR_W-1:0]) + j) % DEPTH;
         fif.pop_data[j*LINE +: LINE] = rd_dat[addr % NBANK];
      end
   end

   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      packed_fifo_bank #(.LINE(LINE), .ROWS(ROWS)) u_bank (
         .clk    (clk),
         .wr_en  (wr_en[b]),
         .wr_row (wr_row[b]),
         .wr_dat (wr_dat[b]),
         .rd_row (rd_row[b]),
         .rd_dat (rd_dat[b])
      );
   end

   assign fif.count      = cnt;
   assign fif.full       = (cnt == PTR_W'(DEPTH));
   assign fif.empty      = (cnt == '0);
   assign fif.push_ready = (free >= PTR_W'(PUSH_W));
   assign fif.pop_avail  = OC_W'(avail_n);

`ifdef PACKED_FIFO_ERR_EN
   logic ovf_q, ovf_d, unf_q, unf_d;

   always_comb begin
      ovf_d = ovf_q | ((push_n != '0) && !push_ok);
      unf_d = unf_q | (pop_n > avail_n);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign err = {ovf_q, unf_q};
`endif

endmodule

// File: tb/tb_packed_fifo.sv
// Directed bench for packed_fifo: hand-computed vector table plus queue-model corner sequences.
module tb_packed_fifo;
   import packed_fifo_pkg::*;

   localparam int LINE   = 18;
   localparam int DEPTH  = 64;
   localparam int PUSH_W = 4;
   localparam int POP_W  = 2;
   localparam int PC_W   = lane_w(PUSH_W);
   localparam int OC_W   = lane_w(POP_W);

   localparam logic [LINE-1:0] A = 18'h000A1, B = 18'h000B2, C = 18'h000C3, D = 18'h000D4;
   localparam logic [LINE-1:0] E = 18'h000E5, F = 18'h000F6, G = 18'h00107, Z = 18'h00000;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   packed_fifo_if #(.LINE(LINE), .DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W)) fif ();
`ifdef PACKED_FIFO_ERR_EN
   logic [1:0] err;
`endif

   packed_fifo #(.LINE(LINE), .DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .fif     (fif)
`ifdef PACKED_FIFO_ERR_EN
      ,
      .err     (err)
`endif
   );

   typedef struct {
      int                     pn;
      logic [PUSH_W*LINE-1:0] pd;
      int                     pc;
      int                     pre;
      int                     cnt;
      int                     av;
      logic [LINE-1:0]        l0;
      logic [LINE-1:0]        l1;
      logic [1:0]             er;
   } vec_t;

   vec_t            vt [8];
   int              total = 0;
   int              bad = 0;
   logic [LINE-1:0] mq [$];
   bit              m_ov = 1'b0;
   bit              m_un = 1'b0;
   int              seq = 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [LINE-1:0] el(input int n);
      return LINE'(n * 37 + 5);
   endfunction

   task automatic check_state(input string tag);
      int sz;
      int av;
      sz = mq.size();
      av = (sz < POP_W) ? sz : POP_W;
      chk({tag, ".count"},      64'(fif.count),      64'(sz));
      chk({tag, ".empty"},      64'(fif.empty),      64'(sz == 0));
      chk({tag, ".full"},       64'(fif.full),       64'(sz == DEPTH));
      chk({tag, ".push_ready"}, 64'(fif.push_ready), 64'(DEPTH - sz >= PUSH_W));
      chk({tag, ".pop_avail"},  64'(fif.pop_avail),  64'(av));
      for (int j = 0; j < av; j++)
         chk($sformatf("%s.lane%0d", tag, j), 64'(fif.pop_data[j*LINE +: LINE]), 64'(mq[j]));
`ifdef PACKED_FIFO_ERR_EN
      chk({tag, ".err"}, 64'(err), 64'({m_ov, m_un}));
`endif
   endtask

   // One clock of traffic against the queue model; entered and left at posedge+1.
   task automatic cycle(input int pn, input int pc, input string tag);
      logic [PUSH_W*LINE-1:0] pd;
      int free;
      int avail;
      int eff;
      for (int i = 0; i < PUSH_W; i++) pd[i*LINE +: LINE] = (i < pn) ? el(seq + i) : '1;
      free  = DEPTH - mq.size();
      avail = (mq.size() < POP_W) ? mq.size() : POP_W;
      fif.push_count = PC_W'(pn);
      fif.push_data  = pd;
      fif.pop_count  = OC_W'(pc);
      @(posedge clk);
      #1;
      fif.push_count = '0;
      fif.pop_count  = '0;
      if (pn <= free) begin
         for (int i = 0; i < pn; i++) mq.push_back(el(seq + i));
         seq += pn;
      end else if (pn != 0) begin
         m_ov = 1'b1;
      end
      if (pc > avail) m_un = 1'b1;
      eff = (pc < avail) ? pc : avail;
      repeat (eff) void'(mq.pop_front());
      check_state(tag);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      mq.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{3, {Z, C, B, A}, 0, 0, 3, 2, A, B, 2'b00};
      vt[1] = '{0, {Z, Z, Z, Z}, 1, 2, 2, 2, B, C, 2'b00};
      vt[2] = '{2, {Z, Z, E, D}, 2, 2, 2, 2, D, E, 2'b00};
      vt[3] = '{0, {Z, Z, Z, Z}, 2, 2, 0, 0, Z, Z, 2'b00};
      vt[4] = '{2, {Z, Z, G, F}, 2, 0, 2, 2, F, G, 2'b01};
      vt[5] = '{0, {Z, Z, Z, Z}, 1, 2, 1, 1, G, Z, 2'b01};
      vt[6] = '{0, {Z, Z, Z, Z}, 2, 1, 0, 0, Z, Z, 2'b01};
      vt[7] = '{1, {Z, Z, Z, A}, 0, 0, 1, 1, A, Z, 2'b01};

      fif.push_count = '0;
      fif.push_data  = '0;
      fif.pop_count  = '0;

      #1;
      check_state("reset_immediate");
      repeat (2) @(posedge clk);
      #1;
      check_state("reset_held");
      @(negedge clk);
      reset_n = 1'b1;

      for (int k = 0; k < 8; k++) begin
         fif.push_count = PC_W'(vt[k].pn);
         fif.push_data  = vt[k].pd;
         fif.pop_count  = OC_W'(vt[k].pc);
         #1;
         chk($sformatf("v%0d.pre_avail", k), 64'(fif.pop_avail), 64'(vt[k].pre));
         @(posedge clk);
         #1;
         fif.push_count = '0;
         fif.pop_count  = '0;
         chk($sformatf("v%0d.count", k), 64'(fif.count), 64'(vt[k].cnt));
         chk($sformatf("v%0d.avail", k), 64'(fif.pop_avail), 64'(vt[k].av));
         chk($sformatf("v%0d.empty", k), 64'(fif.empty), 64'(vt[k].cnt == 0));
         if (vt[k].av > 0) chk($sformatf("v%0d.lane0", k), 64'(fif.pop_data[0 +: LINE]), 64'(vt[k].l0));
         if (vt[k].av > 1) chk($sformatf("v%0d.lane1", k), 64'(fif.pop_data[LINE +: LINE]), 64'(vt[k].l1));
`ifdef PACKED_FIFO_ERR_EN
         chk($sformatf("v%0d.err", k), 64'(err), 64'(vt[k].er));
`endif
      end

      // Fill to full, then a rejected push, then a rejected push while popping.
      do_reset();
      for (int k = 0; k < 16; k++) cycle(4, 0, $sformatf("fill%0d", k));
      cycle(1, 0, "full_push");
      cycle(1, 2, "full_push_pop");

      // Head parked at address 62 with 62 stored, then a push that must wrap.
      do_reset();
      for (int k = 0; k < 15; k++) cycle(4, 0, $sformatf("pre%0d", k));
      cycle(2, 0, "pre_head62");
      cycle(4, 2, "free2_reject");
      cycle(4, 0, "wrap_push");
      for (int k = 0; k < 32; k++) cycle(0, 2, $sformatf("drain%0d", k));

      for (int k = 0; k < 60; k++) cycle(k % 5, (k * 7) % 3, $sformatf("mix%0d", k));

      // Asynchronous reset in the middle of traffic at 37 stored.
      do_reset();
      for (int k = 0; k < 9; k++) cycle(4, 0, $sformatf("to37_%0d", k));
      cycle(1, 0, "at37");
      #2;
      reset_n = 1'b0;
      mq.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      #1;
      check_state("midrst");
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(1, 0, "post_rst_push");
      cycle(1, 1, "post_rst_flow");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/packed_fifo.md
PACKED_FIFO -- requirements
Module: packed_fifo

Interface
REQ-001 SHALL have parameter LINE, default 18, meaning element width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, meaning capacity in elements; must be a power of two.
REQ-003 SHALL have parameter PUSH_W, default 4, meaning maximum elements pushed per cycle.
REQ-004 SHALL have parameter POP_W, default 2, meaning maximum elements popped per cycle.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-007 SHALL have port push_count, input, clog2(PUSH_W+1) bits, number of elements offered this cycle; 0 means no push.
REQ-008 SHALL have port push_data, input, PUSH_W*LINE bits; lane i is bits [i*LINE +: LINE], and lane 0 is the oldest.
REQ-009 SHALL have port push_ready, output, 1 bit, asserted when free >= PUSH_W.
REQ-010 SHALL have port pop_count, input, clog2(POP_W+1) bits, number of elements consumed this cycle.
REQ-011 SHALL have port pop_data, output, POP_W*LINE bits; lane i is the element at tail+i.
REQ-012 SHALL have port pop_avail, output, clog2(POP_W+1) bits, equal to min(count, POP_W).
REQ-013 SHALL have port count, output, clog2(DEPTH+1) bits, exact occupancy in elements.
REQ-014 SHALL have ports full and empty, outputs, 1 bit each, meaning count==DEPTH and count==0 respectively.

Function
REQ-015 SHALL store elements individually (element granularity) in a circular buffer, with head and tail pointers of clog2(DEPTH)+1 bits including a wrap bit.
REQ-016 SHALL accept a push only when push_count <= free, where free = DEPTH-count sampled at the start of the cycle; the push is all-or-nothing and a rejected push writes nothing.
REQ-017 SHALL write accepted lanes 0..push_count-1 to addresses head..head+push_count-1 modulo DEPTH, and advance head by push_count.
REQ-018 SHALL provide pop_data as first-word-fall-through: lanes 0..pop_avail-1 are valid combinationally from storage, and lanes at or above pop_avail are don't-care.
REQ-019 SHALL clamp a pop to the effective pop of min(pop_count, pop_avail), and advance tail by that amount.
REQ-020 SHALL treat simultaneous push and pop in one cycle as independent: next count = count + accepted push - effective pop.
REQ-021 SHALL NOT pass through elements: an element pushed in cycle N appears on pop_data no earlier than cycle N+1, including when the FIFO is empty.
REQ-022 SHALL NOT let a concurrent pop create room for a same-cycle push: a full FIFO rejects any nonzero push even while popping.
REQ-023 SHALL wrap pointers modulo 2*DEPTH so that full and empty are unambiguous at every occupancy, 0 through DEPTH inclusive.
REQ-024 SHALL derive count, full, empty, push_ready and pop_avail from registered pointers only, with no combinational path from push_count or pop_count.

Reset
REQ-025 SHALL on reset_n low immediately set head=0, tail=0, count=0, empty=1, full=0, push_ready=1 and pop_avail=0.
REQ-026 SHALL discard contents on reset asserted mid-operation, and SHALL NOT reset the storage array.
REQ-027 SHALL accept a push in the first rising edge after reset_n deasserts.

Configuration
REQ-028 SHALL, with macro PACKED_FIFO_ERR_EN defined, add output err[1:0] = {overflow, underflow} as sticky flags.
- overflow sets on a rejected nonzero push.
- underflow sets on pop_count > pop_avail.
- Both flags are cleared only by reset.
REQ-029 SHALL, without PACKED_FIFO_ERR_EN, omit the err port entirely; rejection and clamping behaviour is identical in both builds.

Structure
REQ-030 SHALL place the defaults for LINE, DEPTH, PUSH_W and POP_W, plus pointer, count and lane-count width helper functions, in package packed_fifo_pkg.
REQ-031 SHALL implement storage as sub-module packed_fifo_bank, instantiated NBANK = next power of two >= max(PUSH_W, POP_W) times.
- Element address a maps to bank a mod NBANK.
- Each bank has one write port and one read port.
- DEPTH must be a multiple of NBANK.

Verification
REQ-032 SHALL cover: after reset, push_count=3 with lanes A,B,C -> next cycle count=3, pop_avail=2, pop_data lanes = A,B.
REQ-033 SHALL cover: 16 pushes of 4 (count=64), then push_count=1 -> full=1, push rejected, count stays 64, err[1]=1 when PACKED_FIFO_ERR_EN is defined.
REQ-034 SHALL cover: count=1 with pop_count=2 -> effective pop 1, count=0, empty=1, err[0]=1 when PACKED_FIFO_ERR_EN is defined.
REQ-035 SHALL cover: count=62 with head at address 62, push 4 while popping 2 -> push rejected (free=2), count=60, and later pushes wrap correctly to addresses 62,63,0,1.
REQ-036 SHALL cover: empty FIFO with push 2 and pop 2 in the same cycle -> pop_avail=0 that cycle, count=2 and pop_avail=2 next cycle.
REQ-037 SHALL cover: reset_n pulsed low mid-stream at count=37 -> outputs take reset values immediately with no clock edge, and the next push of X yields pop_data lane 0 = X.
